// File: rtl/io_block.sv
// Programmable I/O block: a 4480-bit serial configuration chain routes 32
// fabric input bits onto 32 output bits with per-bit inversion and optional output flop.
module io_block (
  input  logic       clb_clk,
  input  logic       rst_n,
  input  logic       prog_en,
  input  logic       prog_in,
  output logic       prog_out,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4
);

  localparam int CHAIN_LEN = 4480;

  logic [CHAIN_LEN-1:0] cfg;
  logic [31:0]          in_vec;
  logic [31:0]          mux_val;
  logic [31:0]          out_q;
  logic [31:0]          out_vec;

  assign in_vec = {in4, in3, in2, in1};

  // Bits enter at the top so the first bit shifted in ends up in cfg[0].
  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (prog_en) begin
      cfg <= {prog_in, cfg[CHAIN_LEN-1:1]};
    end
  end

  assign prog_out = cfg[0];

  // Only cfg[255:0] drives routing; byte j = {en, reg, inv, sel[4:0]} for output bit j.
  always_comb begin
    mux_val = '0;
    out_vec = '0;
    for (int j = 0; j < 32; j++) begin
      mux_val[j] = in_vec[cfg[8*j +: 5]] ^ cfg[8*j + 5];
      if (!prog_en && cfg[8*j + 7]) begin
        out_vec[j] = cfg[8*j + 6] ? out_q[j] : mux_val[j];
      end
    end
  end

  // Output flops keep sampling during programming; only the output mux is gated.
  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= mux_val;
    end
  end

  assign {out4, out3, out2, out1} = out_vec;

endmodule

// File: tb/tb_io_block.sv
// Directed self-checking bench for io_block: reset, chain pass-through,
// combinational/inverted/registered routing and mid-program reset.
module tb_io_block;

  logic       clb_clk;
  logic       rst_n;
  logic       prog_en;
  logic       prog_in;
  logic       prog_out;
  logic [7:0] in1, in2, in3, in4;
  logic [7:0] out1, out2, out3, out4;

  int checks;
  int failures;

  logic [4479:0] img;
  logic [7:0]    pat;
  logic [7:0]    exp_seq;

  io_block dut (
    .clb_clk  (clb_clk),
    .rst_n    (rst_n),
    .prog_en  (prog_en),
    .prog_in  (prog_in),
    .prog_out (prog_out),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4)
  );

  initial clb_clk = 1'b0;
  always #5 clb_clk = ~clb_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one bit with prog_en high and returns 1 time unit after the edge.
  task automatic shift_bit(input logic b);
    prog_in = b;
    prog_en = 1'b1;
    @(posedge clb_clk);
    #1;
  endtask

  // Loads image so that afterwards cfg == image (image[0] is shifted first).
  task automatic applyStimulus(input logic [4479:0] image);
    for (int i = 0; i < 4480; i++) begin
      shift_bit(image[i]);
      if (i == 2000) begin
        checkOutput("force_zero_prog", {out4, out3, out2, out1}, 32'h0);
      end
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
    #1;
  endtask

  task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    in1 = a; in2 = b; in3 = c; in4 = d;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    prog_en  = 1'b0;
    prog_in  = 1'b0;
    rst_n    = 1'b0;
    in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom); in4 = 8'($urandom);

    // Reset state
    #12;
    checkOutput("reset_outs", {out4, out3, out2, out1}, 32'h0);
    checkOutput("reset_prog_out", {31'h0, prog_out}, 32'h0);
    @(posedge clb_clk); #1;
    rst_n = 1'b1;
    set_inputs(8'hFF, 8'h5A, 8'hC3, 8'h11);
    @(posedge clb_clk); #1;
    checkOutput("post_reset_outs", {out4, out3, out2, out1}, 32'h0);

    // Chain pass-through with 0xA5, MSB of each byte shifted first
    pat     = 8'hA5;
    exp_seq = 8'b1010_0101;
    for (int k = 0; k < 4480; k++) begin
      shift_bit(pat[7 - (k % 8)]);
      if (k == 4478) checkOutput("chain_before_full", {31'h0, prog_out}, 32'h0);
      if (k == 3000) checkOutput("chain_force_zero", {out4, out3, out2, out1}, 32'h0);
    end
    checkOutput("chain_bit0", {31'h0, prog_out}, {31'h0, exp_seq[7]});
    for (int m = 1; m < 8; m++) begin
      shift_bit(1'b0);
      checkOutput($sformatf("chain_bit%0d", m), {31'h0, prog_out}, {31'h0, exp_seq[7 - m]});
    end
    prog_en = 1'b0;

    // Identity route, combinational
    img = '0;
    for (int j = 0; j < 32; j++) img[8*j +: 8] = 8'h80 | 8'(j);
    applyStimulus(img);
    set_inputs(8'h3C, 8'hF0, 8'h81, 8'h7E);
    checkOutput("identity_a", {out4, out3, out2, out1}, 32'h7E81F03C);
    set_inputs(8'h55, 8'hAA, 8'h01, 8'h80);
    checkOutput("identity_b", {out4, out3, out2, out1}, 32'h8001AA55);

    // prog_en gates the outputs combinationally (raised and dropped between edges)
    prog_en = 1'b1;
    #1;
    checkOutput("prog_en_gate", {out4, out3, out2, out1}, 32'h0);
    prog_en = 1'b0;
    #1;
    checkOutput("prog_en_release", {out4, out3, out2, out1}, 32'h8001AA55);

    // Inversion plus crossing: out1[j] = ~in4[j], other outputs disabled
    img = '0;
    for (int j = 0; j < 8; j++) img[8*j +: 8] = 8'hA0 | 8'(24 + j);
    applyStimulus(img);
    set_inputs(8'h12, 8'h34, 8'h56, 8'h0F);
    checkOutput("invert_cross_a", {out4, out3, out2, out1}, 32'h000000F0);
    set_inputs(8'hFF, 8'hFF, 8'hFF, 8'hA5);
    checkOutput("invert_cross_b", {out4, out3, out2, out1}, 32'h0000005A);

    // Registered identity: one-cycle latency
    img = '0;
    for (int j = 0; j < 32; j++) img[8*j +: 8] = 8'hC0 | 8'(j);
    set_inputs(8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(img);
    @(posedge clb_clk); #1;
    checkOutput("reg_initial", {out4, out3, out2, out1}, 32'h0);
    set_inputs(8'hFF, 8'h00, 8'h00, 8'h00);
    checkOutput("reg_before_edge", {out4, out3, out2, out1}, 32'h0);
    @(posedge clb_clk); #1;
    checkOutput("reg_after_edge", {out4, out3, out2, out1}, 32'h000000FF);

    // Mid-program reset, then a clean identity load
    for (int k = 0; k < 100; k++) shift_bit(1'b1);
    prog_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_prog_out", {31'h0, prog_out}, 32'h0);
    checkOutput("midreset_outs", {out4, out3, out2, out1}, 32'h0);
    @(posedge clb_clk); #1;
    rst_n = 1'b1;
    img = '0;
    for (int j = 0; j < 32; j++) img[8*j +: 8] = 8'h80 | 8'(j);
    applyStimulus(img);
    set_inputs(8'h3C, 8'hF0, 8'h81, 8'h7E);
    checkOutput("midreset_identity", {out4, out3, out2, out1}, 32'h7E81F03C);
    @(posedge clb_clk); #1;
    checkOutput("midreset_prog_out_tail", {31'h0, prog_out}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
